// File: rtl/sum_accum.sv
// sum_accum: accumulates COUNT adder results ({Ovf,Sum}, 0..30) per frame
// into a saturating running total and presents it through a valid/ack
// handshake. All outputs come straight from registers.
module sum_accum #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             In_Valid,
  input  logic [3:0]       Sum_In,
  input  logic             Ovf_In,
  output logic             In_Ready,
  output logic [ACC_W-1:0] Acc_Out,
  output logic             Acc_Valid,
  input  logic             Acc_Ack,
  output logic             Acc_Sat,
  output logic             Busy,
  output logic [3:0]       Cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Count value at which the next accept closes the frame.
  localparam logic [3:0]       CNT_LAST = 4'(COUNT - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic             sat_r, sat_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             ready_r, busy_r;
  logic [ACC_W:0]   sum_s;

  // One extra bit of headroom: the carry out flags that the total clipped.
  assign sum_s = {1'b0, acc_r} + {{(ACC_W-4){1'b0}}, Ovf_In, Sum_In};

  // Next-state and next-value decode for the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sat_nxt_s   = sat_r;
    valid_nxt_s = valid_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          acc_nxt_s   = {ACC_W{1'b0}};
          cnt_nxt_s   = 4'd0;
          sat_nxt_s   = 1'b0;
          valid_nxt_s = 1'b0;
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (In_Valid) begin
          if (sum_s[ACC_W]) begin
            acc_nxt_s = ACC_MAX;
            sat_nxt_s = 1'b1;
          end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
          end
          cnt_nxt_s = cnt_r + 4'd1;
          if (cnt_r == CNT_LAST) begin
            valid_nxt_s = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        // Start arriving with Ack is dropped; a new frame needs Start in IDLE.
        if (Acc_Ack) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; In_Ready/Busy are registered from next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= 4'd0;
      sat_r   <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sat_r   <= sat_nxt_s;
      valid_r <= valid_nxt_s;
      ready_r <= (state_nxt_s == ACCUM);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  assign In_Ready  = ready_r;
  assign Busy      = busy_r;
  assign Acc_Out   = acc_r;
  assign Cnt       = cnt_r;
  assign Acc_Sat   = sat_r;
  assign Acc_Valid = valid_r;

endmodule

// File: tb/tb_sum_accum.sv
// Directed testbench for sum_accum: a vector table for the COUNT=4/ACC_W=8
// instance plus a hand-written saturation sequence on a COUNT=2/ACC_W=5 one.
module tb_sum_accum;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start, In_Valid, Ovf_In, Acc_Ack;
  logic [3:0] Sum_In;
  logic       In_Ready, Acc_Valid, Acc_Sat, Busy;
  logic [7:0] Acc_Out;
  logic [3:0] Cnt;

  logic       s_start, s_valid, s_ovf, s_ack;
  logic [3:0] s_sum;
  logic       s_ready, s_acc_valid, s_sat, s_busy;
  logic [4:0] s_acc;
  logic [3:0] s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  sum_accum #(.COUNT(4), .ACC_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid),
    .Sum_In(Sum_In), .Ovf_In(Ovf_In), .In_Ready(In_Ready),
    .Acc_Out(Acc_Out), .Acc_Valid(Acc_Valid), .Acc_Ack(Acc_Ack),
    .Acc_Sat(Acc_Sat), .Busy(Busy), .Cnt(Cnt)
  );

  sum_accum #(.COUNT(2), .ACC_W(5)) dut_s (
    .Clk(Clk), .Rst(Rst), .Start(s_start), .In_Valid(s_valid),
    .Sum_In(s_sum), .Ovf_In(s_ovf), .In_Ready(s_ready),
    .Acc_Out(s_acc), .Acc_Valid(s_acc_valid), .Acc_Ack(s_ack),
    .Acc_Sat(s_sat), .Busy(s_busy), .Cnt(s_cnt)
  );

  typedef struct {
    logic       rst, start, iv;
    logic [4:0] val;
    logic       ack;
    logic [7:0] acc;
    logic [3:0] cnt;
    logic       vld, sat, rdy, bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic start, input logic iv,
                              input logic [4:0] val, input logic ack,
                              input logic [7:0] acc, input logic [3:0] cnt,
                              input logic vld, input logic sat,
                              input logic rdy, input logic bsy);
    vec_t v;
    v.rst = rst; v.start = start; v.iv = iv; v.val = val; v.ack = ack;
    v.acc = acc; v.cnt = cnt; v.vld = vld; v.sat = sat; v.rdy = rdy; v.bsy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; In_Valid = 1'b0; Sum_In = 4'd0; Ovf_In = 1'b0; Acc_Ack = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_sum = 4'd0; s_ovf = 1'b0; s_ack = 1'b0;

    //  rst start iv val ack | acc cnt vld sat rdy bsy
    // Reset with Start/In_Valid active, then ignored input in IDLE.
    add(1, 1, 1, 5'd5,  0,  8'd0,  4'd0, 0, 0, 0, 0);
    add(1, 1, 1, 5'd5,  0,  8'd0,  4'd0, 0, 0, 0, 0);
    add(0, 0, 1, 5'd5,  1,  8'd0,  4'd0, 0, 0, 0, 0);
    // Nominal frame: 5, 10, 30, 17 -> 62.
    add(0, 1, 0, 5'd0,  0,  8'd0,  4'd0, 0, 0, 1, 1);
    add(0, 0, 1, 5'd5,  0,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 0, 1, 5'd10, 0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(0, 0, 1, 5'd30, 0,  8'd45, 4'd3, 0, 0, 1, 1);
    add(0, 0, 1, 5'd17, 0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 0, 0, 5'd0,  0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 0, 0, 5'd0,  1,  8'd62, 4'd4, 0, 0, 0, 0);
    // Gapped frame; gap rows carry junk data, stray Start and stray Ack.
    add(0, 1, 0, 5'd0,  0,  8'd0,  4'd0, 0, 0, 1, 1);
    add(0, 0, 1, 5'd5,  0,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 1, 0, 5'd31, 0,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 0, 0, 5'd31, 1,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 0, 0, 5'd0,  0,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 0, 1, 5'd10, 0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(0, 0, 0, 5'd3,  0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(0, 0, 0, 5'd3,  0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(0, 0, 0, 5'd3,  0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(0, 0, 1, 5'd30, 0,  8'd45, 4'd3, 0, 0, 1, 1);
    add(0, 0, 0, 5'd0,  0,  8'd45, 4'd3, 0, 0, 1, 1);
    add(0, 0, 0, 5'd0,  0,  8'd45, 4'd3, 0, 0, 1, 1);
    add(0, 0, 0, 5'd0,  0,  8'd45, 4'd3, 0, 0, 1, 1);
    add(0, 0, 1, 5'd17, 0,  8'd62, 4'd4, 1, 0, 0, 1);
    // HOLD robustness: dropped inputs, then Start+Ack together -> IDLE only.
    add(0, 0, 1, 5'd7,  0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 0, 1, 5'd7,  0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 0, 1, 5'd7,  0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 0, 1, 5'd7,  0,  8'd62, 4'd4, 1, 0, 0, 1);
    add(0, 1, 0, 5'd0,  1,  8'd62, 4'd4, 0, 0, 0, 0);
    add(0, 1, 0, 5'd0,  0,  8'd0,  4'd0, 0, 0, 1, 1);
    // Mid-frame reset after two accepts.
    add(0, 0, 1, 5'd5,  0,  8'd5,  4'd1, 0, 0, 1, 1);
    add(0, 0, 1, 5'd10, 0,  8'd15, 4'd2, 0, 0, 1, 1);
    add(1, 0, 1, 5'd3,  0,  8'd0,  4'd0, 0, 0, 0, 0);
    add(0, 0, 1, 5'd3,  0,  8'd0,  4'd0, 0, 0, 0, 0);
    add(0, 0, 0, 5'd0,  0,  8'd0,  4'd0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      Rst      = vecs[i].rst;
      Start    = vecs[i].start;
      In_Valid = vecs[i].iv;
      Ovf_In   = vecs[i].val[4];
      Sum_In   = vecs[i].val[3:0];
      Acc_Ack  = vecs[i].ack;
      tick();
      chk($sformatf("row%0d_acc", i),   int'(Acc_Out),   int'(vecs[i].acc));
      chk($sformatf("row%0d_cnt", i),   int'(Cnt),       int'(vecs[i].cnt));
      chk($sformatf("row%0d_valid", i), int'(Acc_Valid), int'(vecs[i].vld));
      chk($sformatf("row%0d_sat", i),   int'(Acc_Sat),   int'(vecs[i].sat));
      chk($sformatf("row%0d_ready", i), int'(In_Ready),  int'(vecs[i].rdy));
      chk($sformatf("row%0d_busy", i),  int'(Busy),      int'(vecs[i].bsy));
    end

    // Saturation on the narrow instance: 30 + 30 clips to 31.
    Rst = 1'b0; Start = 1'b0; In_Valid = 1'b0; Acc_Ack = 1'b0;
    s_start = 1'b1;
    tick();
    chk("sat_start_ready", int'(s_ready), 1);
    s_start = 1'b0; s_valid = 1'b1; s_ovf = 1'b1; s_sum = 4'd14;
    tick();
    chk("sat_first_acc", int'(s_acc), 30);
    chk("sat_first_flag", int'(s_sat), 0);
    tick();
    chk("sat_second_acc", int'(s_acc), 31);
    chk("sat_second_flag", int'(s_sat), 1);
    chk("sat_valid", int'(s_acc_valid), 1);
    chk("sat_cnt", int'(s_cnt), 2);
    s_valid = 1'b0; s_ack = 1'b1;
    tick();
    chk("sat_ack_valid", int'(s_acc_valid), 0);
    chk("sat_ack_acc", int'(s_acc), 31);
    chk("sat_ack_flag", int'(s_sat), 1);
    chk("sat_ack_busy", int'(s_busy), 0);
    s_ack = 1'b0; s_start = 1'b1;
    tick();
    chk("sat_restart_acc", int'(s_acc), 0);
    chk("sat_restart_flag", int'(s_sat), 0);
    s_start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
